// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the scrolling HEX display controller.
//   state_t       : controller FSM states
//   seg_t         : one raw 7-segment pattern (active-low segments)
//   NUM_HEX       : number of displays driven (HEX0..HEX5)
//   BLANK_DEFAULT : all segments off
package hex_scroll_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [6:0] seg_t;

    localparam int unsigned NUM_HEX       = 6;
    localparam seg_t        BLANK_DEFAULT = 7'b111_1111;

endpackage

// File: rtl/hex_tick_gen.sv
// Step-rate timer for the scroll controller.
// Ports:
//   CLOCK  in  system clock
//   RESET  in  synchronous active-high reset
//   CLR    in  reload the timer so a full TICK_DIV period starts next cycle
//   EN     in  count this cycle
//   TICK   out high on the enabled cycle that completes TICK_DIV enabled cycles
module hex_tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int unsigned    TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  LOAD = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt_q;

    // Counts down from TICK_DIV-1; zero marks the last cycle of the period.
    assign TICK = EN && (cnt_q == '0);

    always_ff @(posedge CLOCK) begin
        if (RESET || CLR) begin
            cnt_q <= LOAD;
        end else if (EN) begin
            cnt_q <= (cnt_q == '0) ? LOAD : cnt_q - TW'(1);
        end
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolling-message controller for six 7-segment displays.
// A message is written into an internal buffer, then scrolled right-to-left
// across HEX0..HEX5, one step every TICK_DIV unheld clock cycles.
// Ports:
//   CLOCK, RESET     system clock, synchronous active-high reset
//   WR_EN/ADDR/DATA  message buffer write port (usable in any state)
//   LEN              message length, sampled with START (clamped to MSG_DEPTH)
//   START            start/restart a pass (ignored when LEN is zero)
//   STOP             abort and blank (wins over START)
//   HOLD             freeze the step timer
//   LOOP             at end of pass: 1 = wrap to step 0, 0 = finish
//   BUSY             high while running
//   DONE             one-cycle pulse when a non-looping pass ends
//   HEX0..HEX5       registered segment patterns
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int unsigned MSG_DEPTH = 16,
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter seg_t        BLANK     = BLANK_DEFAULT
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         WR_EN,
    input  logic [$clog2(MSG_DEPTH)-1:0] WR_ADDR,
    input  logic [6:0]                   WR_DATA,
    input  logic [$clog2(MSG_DEPTH):0]   LEN,
    input  logic                         START,
    input  logic                         STOP,
    input  logic                         HOLD,
    input  logic                         LOOP,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [6:0]                   HEX0,
    output logic [6:0]                   HEX1,
    output logic [6:0]                   HEX2,
    output logic [6:0]                   HEX3,
    output logic [6:0]                   HEX4,
    output logic [6:0]                   HEX5
);

    localparam int unsigned AW = $clog2(MSG_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(MSG_DEPTH + 6);

    state_t         state_q, state_n;
    logic [SW-1:0]  s_q, s_n;
    logic [LW-1:0]  len_q, len_n;
    logic           fin_q, fin_n;
    logic           tmr_clr, tmr_en, tick;
    logic           start_ok;
    logic [SW-1:0]  last_step;

    seg_t           mem_q [MSG_DEPTH];
    seg_t           hex_q [NUM_HEX];
    seg_t           hex_n [NUM_HEX];
    logic           busy_q, busy_n;
    logic           done_q, done_n;
    logic [SW-1:0]  diff;

    assign start_ok  = START && (LEN != '0);
    assign tmr_en    = (state_q == RUN) && !HOLD;
    assign last_step = SW'(len_q) + SW'(5);

    hex_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .CLR   (tmr_clr),
        .EN    (tmr_en),
        .TICK  (tick)
    );

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            s_q     <= '0;
            len_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            s_q     <= s_n;
            len_q   <= len_n;
            fin_q   <= fin_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        len_n   = len_q;
        fin_n   = 1'b0;
        tmr_clr = 1'b0;
        if (STOP) begin
            state_n = IDLE;
            s_n     = '0;
            tmr_clr = 1'b1;
        end else if (start_ok) begin
            state_n = RUN;
            s_n     = '0;
            len_n   = (LEN > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : LEN;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: tmr_clr = 1'b1;
                RUN: begin
                    if (tick) begin
                        if (s_q == last_step) begin
                            s_n = '0;
                            if (!LOOP) begin
                                state_n = IDLE;
                                fin_n   = 1'b1;
                            end
                        end else begin
                            s_n = s_q + SW'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    s_n     = '0;
                end
            endcase
        end
    end

    // Output logic: HEXk shows mem[s-k] while that index lies inside the message.
    // DONE comes from fin_q so it lines up with the cycle BUSY drops.
    always_comb begin
        busy_n = (state_q == RUN);
        done_n = fin_q;
        diff   = '0;
        for (int unsigned k = 0; k < NUM_HEX; k++) begin
            hex_n[k] = BLANK;
            if ((state_q == RUN) && (s_q >= SW'(k))) begin
                diff = s_q - SW'(k);
                if (diff < SW'(len_q)) begin
                    hex_n[k] = mem_q[AW'(diff)];
                end
            end
        end
    end

    // Message buffer
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
                mem_q[i] <= BLANK;
            end
        end else if (WR_EN) begin
            mem_q[WR_ADDR] <= WR_DATA;
        end
    end

    // Output registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_HEX; k++) begin
                hex_q[k] <= BLANK;
            end
        end else begin
            busy_q <= busy_n;
            done_q <= done_n;
            for (int unsigned k = 0; k < NUM_HEX; k++) begin
                hex_q[k] <= hex_n[k];
            end
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
module tb_hex_scroll_ctrl;

    localparam logic [6:0] B = 7'h7F;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       WR_EN = 1'b0;
    logic [2:0] WR_ADDR = '0;
    logic [6:0] WR_DATA = '0;
    logic [3:0] LEN = '0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       HOLD = 1'b0;
    logic       LOOP = 1'b0;
    logic       BUSY, DONE;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [41:0] hexv;

    int total = 0;
    int bad   = 0;

    hex_scroll_ctrl #(
        .MSG_DEPTH (8),
        .TICK_DIV  (4),
        .BLANK     (7'h7F)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .WR_EN   (WR_EN),
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA),
        .LEN     (LEN),
        .START   (START),
        .STOP    (STOP),
        .HOLD    (HOLD),
        .LOOP    (LOOP),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .HEX0    (HEX0),
        .HEX1    (HEX1),
        .HEX2    (HEX2),
        .HEX3    (HEX3),
        .HEX4    (HEX4),
        .HEX5    (HEX5)
    );

    always #5 CLOCK = ~CLOCK;

    assign hexv = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    function automatic logic [41:0] p6(input logic [6:0] h5, h4, h3, h2, h1, h0);
        return {h5, h4, h3, h2, h1, h0};
    endfunction

    // One clock edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [6:0] d);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        step();
        WR_EN = 1'b0;
    endtask

    task automatic go(input logic [3:0] l);
        START = 1'b1; LEN = l;
        step();
        START = 1'b0; LEN = '0;
    endtask

    initial begin
        // Reset
        run(2);
        RESET = 1'b0;
        chk("rst_hex", hexv, p6(B, B, B, B, B, B));
        chk("rst_busy", 42'(BUSY), 42'd0);
        chk("rst_done", 42'(DONE), 42'd0);

        // Empty buffer scroll
        go(4'd3);                                   // edge N
        step();                                     // N+1
        chk("empty_busy", 42'(BUSY), 42'd1);
        chk("empty_s0", hexv, p6(B, B, B, B, B, B));
        run(8);                                     // N+9, step 2
        chk("empty_s2", hexv, p6(B, B, B, B, B, B));
        STOP = 1'b1; step(); STOP = 1'b0; step();
        chk("empty_stop_busy", 42'(BUSY), 42'd0);

        // Basic pass
        wr(3'd0, 7'h40);
        wr(3'd1, 7'h79);
        wr(3'd2, 7'h24);
        go(4'd3);                                   // N
        step();                                     // N+1
        chk("basic_busy", 42'(BUSY), 42'd1);
        chk("basic_s0a", hexv, p6(B, B, B, B, B, 7'h40));
        run(3);                                     // N+4
        chk("basic_s0b", hexv, p6(B, B, B, B, B, 7'h40));
        step();                                     // N+5
        chk("basic_s1", hexv, p6(B, B, B, B, 7'h40, 7'h79));
        run(4);                                     // N+9
        chk("basic_s2", hexv, p6(B, B, B, 7'h40, 7'h79, 7'h24));
        run(20);                                    // N+29, step 7
        chk("basic_s7", hexv, p6(7'h24, B, B, B, B, B));
        run(4);                                     // N+33, step 8
        chk("basic_s8", hexv, p6(B, B, B, B, B, B));
        run(3);                                     // N+36
        chk("basic_busy_end", 42'(BUSY), 42'd1);
        chk("basic_done_early", 42'(DONE), 42'd0);
        step();                                     // N+37
        chk("basic_done", 42'(DONE), 42'd1);
        chk("basic_busy_fall", 42'(BUSY), 42'd0);
        chk("basic_hex_end", hexv, p6(B, B, B, B, B, B));
        step();                                     // N+38
        chk("basic_done_once", 42'(DONE), 42'd0);

        // Loop and HOLD
        LOOP = 1'b1;
        go(4'd3);                                   // N
        run(33);                                    // N+33
        chk("loop_s8", hexv, p6(B, B, B, B, B, B));
        chk("loop_busy8", 42'(BUSY), 42'd1);
        run(4);                                     // N+37, wrapped to step 0
        chk("loop_wrap", hexv, p6(B, B, B, B, B, 7'h40));
        chk("loop_nodone", 42'(DONE), 42'd0);
        chk("loop_busy", 42'(BUSY), 42'd1);
        step();                                     // N+38
        HOLD = 1'b1;
        run(10);                                    // N+48
        HOLD = 1'b0;
        run(2);                                     // N+50
        chk("hold_s0", hexv, p6(B, B, B, B, B, 7'h40));
        step();                                     // N+51
        chk("hold_s1", hexv, p6(B, B, B, B, 7'h40, 7'h79));

        // STOP and START together
        STOP = 1'b1; START = 1'b1; LEN = 4'd3;
        step();
        STOP = 1'b0; START = 1'b0; LEN = '0; LOOP = 1'b0;
        step();
        chk("prio_busy", 42'(BUSY), 42'd0);
        chk("prio_hex", hexv, p6(B, B, B, B, B, B));
        chk("prio_done", 42'(DONE), 42'd0);

        // START with LEN=0
        go(4'd0);
        step();
        chk("len0_busy", 42'(BUSY), 42'd0);
        chk("len0_hex", hexv, p6(B, B, B, B, B, B));

        // LEN clamp
        go(4'd12);                                  // N
        run(21);                                    // N+21, step 5
        chk("clamp_s5", hexv, p6(7'h40, 7'h79, 7'h24, B, B, B));
        run(35);                                    // N+56
        chk("clamp_busy", 42'(BUSY), 42'd1);
        chk("clamp_nodone", 42'(DONE), 42'd0);
        step();                                     // N+57
        chk("clamp_done", 42'(DONE), 42'd1);
        chk("clamp_idle", 42'(BUSY), 42'd0);

        // Mid-run write, restart and reset
        go(4'd3);                                   // N
        run(9);                                     // N+9, step 2
        chk("mid_s2", hexv, p6(B, B, B, 7'h40, 7'h79, 7'h24));
        wr(3'd0, 7'h12);                            // write at edge N+10
        chk("mid_wr_old", hexv, p6(B, B, B, 7'h40, 7'h79, 7'h24));
        step();                                     // N+11
        chk("mid_wr_new", hexv, p6(B, B, B, 7'h12, 7'h79, 7'h24));
        run(10);                                    // N+21, step 5
        chk("mid_s5", hexv, p6(7'h12, 7'h79, 7'h24, B, B, B));
        go(4'd3);                                   // restart edge R
        step();                                     // R+1
        chk("restart_s0", hexv, p6(B, B, B, B, B, 7'h12));
        chk("restart_busy", 42'(BUSY), 42'd1);
        run(4);                                     // R+5
        chk("restart_s1", hexv, p6(B, B, B, B, 7'h12, 7'h79));
        run(16);                                    // R+21, step 5
        chk("restart_s5", hexv, p6(7'h12, 7'h79, 7'h24, B, B, B));
        RESET = 1'b1;
        step();                                     // R+22
        chk("midrst_hex", hexv, p6(B, B, B, B, B, B));
        chk("midrst_busy", 42'(BUSY), 42'd0);
        chk("midrst_done", 42'(DONE), 42'd0);
        step();
        RESET = 1'b0;
        go(4'd3);
        step();
        chk("midrst_mem", hexv, p6(B, B, B, B, B, B));
        chk("midrst_rerun", 42'(BUSY), 42'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Scrolling-message controller for the six 7-segment displays HEX5..HEX0. A requester loads raw segment patterns into an internal message buffer through a write port, then starts a scroll. The block steps the message right-to-left across the displays at a programmable rate, with pause, stop, restart and loop control. It sits between board-level control logic (KEY/SW decoding) and the HEX outputs, replacing direct per-display writes.

## Interface
- MSG_DEPTH, 16: message buffer entries; must be a power of two, ≥ 8.
- TICK_DIV, 25_000_000: clock cycles per scroll step; must be ≥ 1.
- BLANK, 7'b111_1111: pattern driven for "no character" (all segments off, active-low segments).
- CLOCK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- WR_EN  in  1  write strobe into the message buffer.
- WR_ADDR  in  $clog2(MSG_DEPTH)  buffer index to write.
- WR_DATA  in  7  raw segment pattern to store.
- LEN  in  $clog2(MSG_DEPTH)+1  message length, sampled only with START.
- START  in  1  begin, or restart, a scroll.
- STOP  in  1  abort the scroll and blank the displays.
- HOLD  in  1  freeze the step timer while high.
- LOOP  in  1  sampled at end of pass; 1 = wrap to step 0.
- BUSY  out  1  1 while in RUN.
- DONE  out  1  one-cycle pulse at the end of a non-looping pass.
- HEX0..HEX5  out  7 each  segment patterns.

## Operation
- States:
  - IDLE: displays blank, timer cleared.
  - RUN: step counter s advances every TICK_DIV unheld cycles.
- Display mapping at step s:
  - HEXk shows mem[s−k] when 0 ≤ s−k < L, otherwise BLANK.
  - Step 0 therefore puts mem[0] on HEX0 only; text moves toward HEX5.
- Pass length: steps 0..L+5, i.e. L+6 steps. The final step is all-BLANK.
- Length handling:
  - L = min(LEN, MSG_DEPTH), latched at START.
  - START with LEN=0 is ignored: no state change, no DONE.
- IDLE→RUN on START (LEN>0): s←0, timer←0.
- Restart: START in RUN restarts at s=0 with the newly sampled L.
- End of the last step:
  - LOOP=1: s←0, stay in RUN.
  - LOOP=0: IDLE, DONE=1 for one cycle.
- STOP in any state: IDLE, s←0, timer←0, no DONE. STOP has priority over START in the same cycle.
- HOLD=1 in RUN freezes the timer and s. Any pending step is taken on the first cycle with HOLD=0.
- Writes:
  - WR_EN is accepted in any state, including RUN. Contents are not cleared on START or STOP.
  - A write to a displayed index appears on HEX one cycle after the write edge.
- Reset values: state IDLE, s=0, timer=0, BUSY=0, DONE=0, HEX0..HEX5=BLANK, all mem entries=BLANK. RESET overrides every other input.
- Widths:
  - s is $clog2(MSG_DEPTH+6) bits.
  - The timer counts 0..TICK_DIV−1 and is $clog2(TICK_DIV) bits, minimum 1.
  - No arithmetic may wrap inside a pass.

## Timing
- All outputs are registered. HEX, BUSY and DONE reflect the state/s/mem of the previous cycle.
- START sampled at edge N:
  - BUSY=1 and the step-0 pattern are visible after edge N+1.
- Step duration:
  - With HOLD=0, each step lasts exactly TICK_DIV cycles.
  - The full pass lasts (L+6)·TICK_DIV cycles.
- DONE:
  - Asserts on the same cycle BUSY falls.
  - HEX is already BLANK at that point, because the last step is blank.
- STOP sampled at edge N: BUSY=0 and all HEX=BLANK after edge N+1.
- TICK_DIV=1: s advances every unheld cycle.

## Structure
- Package hex_scroll_pkg holds:
  - the state enum {IDLE, RUN};
  - seg_t (logic [6:0]);
  - NUM_HEX = 6;
  - the default BLANK constant.
- Sub-module hex_tick_gen: parameterised down-counter with clear and enable inputs, emitting a one-cycle tick after TICK_DIV enabled cycles.
- Top level holds the FSM, step counter, buffer registers and the six HEX output registers.

## Test plan
All scenarios use MSG_DEPTH=8 and TICK_DIV=4.
- **Reset.** Assert RESET for 2 cycles. Expect all HEX=7'h7F, BUSY=0, DONE=0. Then START with LEN=3 and no writes: every step shows all 7'h7F.
- **Basic pass.**
  - Stimulus: write mem[0..2]=7'h40,7'h79,7'h24; LEN=3; START.
  - First 4 cycles: HEX0=7'h40, others blank.
  - Next step: HEX1=7'h40, HEX0=7'h79.
  - After 36 cycles: DONE pulses once, BUSY falls, all HEX blank.
- **Loop and HOLD.**
  - Same message with LOOP=1: after step 8 the display returns to the step-0 pattern, with no DONE.
  - HOLD=1 for 10 cycles mid-step: the step ends exactly 10 cycles later.
- **Control priority.**
  - STOP and START in the same cycle: BUSY=0, HEX blank.
  - START with LEN=0: nothing changes.
  - LEN=12: clamps to 8, giving 14 steps and DONE after 56 cycles.
- **Mid-run events.**
  - Write mem[0]=7'h12 while it is displayed on HEX2: HEX2=7'h12 the cycle after the write.
  - START at step 5: restarts at step 0.
  - RESET at step 5: all outputs take reset values after one edge.
